// File: rtl/seq_alu_if.sv
// rtl/seq_alu_if.sv - operand/result handshake bundle for seq_alu
interface seq_alu_if #(
  parameter int WIDTH = 4
);
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   in1;
  logic [WIDTH-1:0]   in2;
  logic [1:0]         opcode;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] result;
  logic               flag_carry;
  logic               flag_zero;
  logic               flag_dbz;

  modport master (
    output in_valid, in1, in2, opcode, out_ready,
    input  in_ready, out_valid, result, flag_carry, flag_zero, flag_dbz
  );

  modport slave (
    input  in_valid, in1, in2, opcode, out_ready,
    output in_ready, out_valid, result, flag_carry, flag_zero, flag_dbz
  );
endinterface

// File: rtl/seq_alu.sv
// rtl/seq_alu.sv - registered add/sub/mul/div ALU with iterative restoring divider
module seq_alu #(
  parameter int WIDTH      = 4,
  parameter bit DIV_ENABLE = 1'b1
) (
  input logic     clk,
  input logic     rst_n,
  seq_alu_if.slave bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DIV  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state;
  logic [CW-1:0]      cnt;
  logic [WIDTH-1:0]   rem;
  logic [WIDTH-1:0]   quot;
  logic [WIDTH-1:0]   dvsr;
  logic               out_valid_q;
  logic [2*WIDTH-1:0] result_q;
  logic               carry_q;
  logic               zero_q;
  logic               dbz_q;

  logic               accept;
  logic               div_start;
  logic [WIDTH:0]     sum;
  logic [WIDTH-1:0]   diff;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] imm_result;
  logic               imm_carry;
  logic               imm_dbz;
  logic [WIDTH:0]     rem_shift;
  logic [WIDTH:0]     trial;
  logic [WIDTH-1:0]   step_rem;
  logic [WIDTH-1:0]   step_quot;

  // Combinational so a draining result and a new accept can share one cycle.
  assign bus.in_ready = (state == S_IDLE) || (state == S_DONE && bus.out_ready);
  assign accept       = bus.in_valid && bus.in_ready;
  assign div_start    = DIV_ENABLE && (bus.opcode == 2'b11) && (bus.in2 != '0);

  assign sum  = {1'b0, bus.in1} + {1'b0, bus.in2};
  assign diff = bus.in1 - bus.in2;
  assign prod = {{WIDTH{1'b0}}, bus.in1} * {{WIDTH{1'b0}}, bus.in2};

  always_comb begin
    imm_result = '0;
    imm_carry  = 1'b0;
    imm_dbz    = 1'b0;
    case (bus.opcode)
      2'b00: begin
        imm_result = {{WIDTH{1'b0}}, sum[WIDTH-1:0]};
        imm_carry  = sum[WIDTH];
      end
      2'b01: begin
        imm_result = {{WIDTH{1'b0}}, diff};
        imm_carry  = (bus.in1 < bus.in2);
      end
      2'b10: imm_result = prod;
      // Only reached for a zero divisor or when the divider is not built.
      default: imm_dbz = 1'b1;
    endcase
  end

  // Restoring step: dividend bits shift out of quot into rem, quotient bits shift in.
  assign rem_shift = {rem, quot[WIDTH-1]};
  assign trial     = rem_shift - {1'b0, dvsr};

  always_comb begin
    step_rem  = rem_shift[WIDTH-1:0];
    step_quot = {quot[WIDTH-2:0], 1'b0};
    if (!trial[WIDTH]) begin
      step_rem  = trial[WIDTH-1:0];
      step_quot = {quot[WIDTH-2:0], 1'b1};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      cnt         <= '0;
      rem         <= '0;
      quot        <= '0;
      dvsr        <= '0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      carry_q     <= 1'b0;
      zero_q      <= 1'b0;
      dbz_q       <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (state == S_DONE && bus.out_ready) begin
            out_valid_q <= 1'b0;
            state       <= S_IDLE;
          end
          if (accept) begin
            if (div_start) begin
              state       <= S_DIV;
              out_valid_q <= 1'b0;
              cnt         <= CW'(WIDTH - 1);
              rem         <= '0;
              quot        <= bus.in1;
              dvsr        <= bus.in2;
            end else begin
              state       <= S_DONE;
              out_valid_q <= 1'b1;
              result_q    <= imm_result;
              carry_q     <= imm_carry;
              zero_q      <= (imm_result == '0);
              dbz_q       <= imm_dbz;
            end
          end
        end
        S_DIV: begin
          rem  <= step_rem;
          quot <= step_quot;
          cnt  <= cnt - 1'b1;
          if (cnt == '0) begin
            state       <= S_DONE;
            out_valid_q <= 1'b1;
            result_q    <= {step_rem, step_quot};
            carry_q     <= 1'b0;
            zero_q      <= ({step_rem, step_quot} == '0);
            dbz_q       <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.out_valid  = out_valid_q;
  assign bus.result     = result_q;
  assign bus.flag_carry = carry_q;
  assign bus.flag_zero  = zero_q;
  assign bus.flag_dbz   = dbz_q;
endmodule

// File: tb/tb_seq_alu.sv
// tb/tb_seq_alu.sv - randomized self-checking bench for seq_alu against an arithmetic model
module tb_seq_alu;
  localparam int W = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   n_vec = 0;
  int   n_bad = 0;

  seq_alu_if #(.WIDTH(W)) bus ();

  seq_alu #(.WIDTH(W), .DIV_ENABLE(1'b1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference: plain integer arithmetic on the operation's meaning.
  task automatic model(input logic [1:0] op, input int a, input int b,
                       output logic [7:0] res, output logic c, output logic z,
                       output logic d, output int lat);
    int r;
    r = 0; c = 1'b0; d = 1'b0; lat = 1;
    case (op)
      2'd0: begin r = (a + b) % (2**W); c = (a + b) >= 2**W; end
      2'd1: begin r = (a - b + 2**W) % (2**W); c = a < b; end
      2'd2: r = a * b;
      default: begin
        if (b == 0) d = 1'b1;
        else begin r = (a % b) * (2**W) + a / b; lat = W + 1; end
      end
    endcase
    res = 8'(r);
    z = (r == 0);
  endtask

  // Presents one operation and waits for its result, leaving out_ready low.
  task automatic issue(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b,
                       output int lat, output logic ready_seen);
    @(negedge clk);
    bus.in_valid = 1'b1; bus.opcode = op; bus.in1 = a; bus.in2 = b; bus.out_ready = 1'b0;
    @(posedge clk); #1;
    bus.in_valid = 1'b0; bus.in1 = 4'($urandom); bus.in2 = 4'($urandom);
    bus.opcode = 2'($urandom);
    lat = 0; ready_seen = 1'b0;
    do begin
      @(negedge clk);
      lat++;
      if (!bus.out_valid && bus.in_ready) ready_seen = 1'b1;
    end while (!bus.out_valid && lat < 20);
  endtask

  task automatic drain();
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.in1 = '0; bus.in2 = '0; bus.opcode = '0;
    #1 rst_n = 1'b0;
    #2;
    n_vec++;
    if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
    n_vec++;
    if ({bus.out_valid, bus.result, bus.flag_carry, bus.flag_zero, bus.flag_dbz} !== 12'h0) begin
      n_bad++;
      $display("FAIL reset_outputs: got v=%b r=%h c=%b z=%b d=%b want all 0",
               bus.out_valid, bus.result, bus.flag_carry, bus.flag_zero, bus.flag_dbz);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_directed();
    logic [1:0] ops[6]  = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd3, 2'd3};
    logic [3:0] as[6]   = '{4'hF, 4'h3, 4'h5, 4'hF, 4'hD, 4'h9};
    logic [3:0] bs[6]   = '{4'h2, 4'h5, 4'h5, 4'hF, 4'h4, 4'h0};
    logic [7:0] exr[6]  = '{8'h01, 8'h0E, 8'h00, 8'hE1, 8'h13, 8'h00};
    logic [2:0] exf[6]  = '{3'b100, 3'b100, 3'b010, 3'b000, 3'b000, 3'b011};
    int         exl[6]  = '{1, 1, 1, 1, 5, 1};
    int lat;
    logic rs;
    for (int i = 0; i < 6; i++) begin
      issue(ops[i], as[i], bs[i], lat, rs);
      n_vec++;
      if (bus.result !== exr[i]) begin n_bad++; $display("FAIL dir%0d_result: got %h want %h", i, bus.result, exr[i]); end
      n_vec++;
      if ({bus.flag_carry, bus.flag_zero, bus.flag_dbz} !== exf[i]) begin
        n_bad++; $display("FAIL dir%0d_flags(czd): got %b want %b", i, {bus.flag_carry, bus.flag_zero, bus.flag_dbz}, exf[i]);
      end
      n_vec++;
      if (lat !== exl[i]) begin n_bad++; $display("FAIL dir%0d_latency: got %0d want %0d", i, lat, exl[i]); end
      n_vec++;
      if (rs !== 1'b0) begin n_bad++; $display("FAIL dir%0d_in_ready_busy: got %b want 0", i, rs); end
      drain();
    end
  endtask

  task automatic test_random();
    logic [1:0] op;
    logic [3:0] a, b;
    logic [7:0] er;
    logic ec, ez, ed, rs;
    int el, lat;
    for (int i = 0; i < 60; i++) begin
      op = 2'($urandom);
      a  = 4'($urandom);
      b  = ($urandom_range(0, 5) == 0) ? 4'h0 : 4'($urandom);
      model(op, int'(a), int'(b), er, ec, ez, ed, el);
      issue(op, a, b, lat, rs);
      n_vec++;
      if (bus.result !== er) begin n_bad++; $display("FAIL rnd%0d_result op=%0d a=%h b=%h: got %h want %h", i, op, a, b, bus.result, er); end
      n_vec++;
      if ({bus.flag_carry, bus.flag_zero, bus.flag_dbz} !== {ec, ez, ed}) begin
        n_bad++; $display("FAIL rnd%0d_flags(czd) op=%0d a=%h b=%h: got %b want %b", i, op, a, b,
                          {bus.flag_carry, bus.flag_zero, bus.flag_dbz}, {ec, ez, ed});
      end
      n_vec++;
      if (lat !== el) begin n_bad++; $display("FAIL rnd%0d_latency op=%0d: got %0d want %0d", i, op, lat, el); end
      repeat ($urandom_range(0, 2)) @(negedge clk);
      drain();
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    logic rs;
    logic [7:0] held;
    issue(2'd2, 4'hB, 4'h7, lat, rs);
    held = bus.result;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_vec++;
      if (bus.result !== 8'h4D || bus.out_valid !== 1'b1) begin
        n_bad++; $display("FAIL stall%0d_hold: got v=%b r=%h want v=1 r=4d", i, bus.out_valid, bus.result);
      end
      n_vec++;
      if (bus.in_ready !== 1'b0) begin n_bad++; $display("FAIL stall%0d_in_ready: got %b want 0", i, bus.in_ready); end
    end
    @(negedge clk);
    bus.out_ready = 1'b1; bus.in_valid = 1'b1; bus.opcode = 2'd0; bus.in1 = 4'h9; bus.in2 = 4'h8;
    #1;
    n_vec++;
    if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_in_ready: got %b want 1", bus.in_ready); end
    @(posedge clk); #1;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    @(negedge clk);
    n_vec++;
    if (bus.out_valid !== 1'b1 || bus.result !== 8'h01 || bus.flag_carry !== 1'b1) begin
      n_bad++; $display("FAIL b2b_result: got v=%b r=%h c=%b want v=1 r=01 c=1", bus.out_valid, bus.result, bus.flag_carry);
    end
    drain();
    n_vec++;
    if (bus.out_valid !== 1'b0 || held !== 8'h4D) begin
      n_bad++; $display("FAIL b2b_drained: got v=%b held=%h want v=0 held=4d", bus.out_valid, held);
    end
  endtask

  task automatic test_reset_mid_div();
    logic seen;
    @(negedge clk);
    bus.in_valid = 1'b1; bus.opcode = 2'd3; bus.in1 = 4'hD; bus.in2 = 4'h4;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_vec++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      n_bad++; $display("FAIL rst_mid_div: got v=%b rdy=%b want v=0 rdy=1", bus.out_valid, bus.in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.out_valid) seen = 1'b1;
    end
    n_vec++;
    if (seen !== 1'b0) begin n_bad++; $display("FAIL rst_mid_div_no_result: got out_valid seen=%b want 0", seen); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_reset_mid_div();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
